// File: rtl/nibble_capture_fifo_if.sv
// Handshake, status and flush signals between the nibble capture FIFO and its writer/reader.
// The slave modport is the FIFO side. The master modport is the environment side.
interface nibble_capture_fifo_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);

  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     overflow;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  flush,
    output in_ready,
    output out_valid,
    output out_data,
    output count,
    output full,
    output empty,
    output overflow
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output flush,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count,
    input  full,
    input  empty,
    input  overflow
  );

endinterface

// File: rtl/nibble_capture_fifo.sv
// Circular FIFO that captures masked nibbles on a valid/ready handshake and keeps a sticky overflow flag.
// Define CAPTURE_CHANGES_EN to store only beats whose data differs from the previously accepted beat.
module nibble_capture_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_capture_fifo_if.slave io_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_store;

  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_empty = (r_count == '0);
    w_push  = io_bus.in_valid & ~w_full;
    w_pop   = ~w_empty & io_bus.out_ready;
  end

`ifdef CAPTURE_CHANGES_EN
  logic [DATA_W-1:0] r_last;
  logic              r_seen;
  logic              w_dup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
      r_seen <= 1'b0;
    end else if (io_bus.flush) begin
      r_last <= '0;
      r_seen <= 1'b0;
    end else if (w_push) begin
      r_last <= io_bus.in_data;
      r_seen <= 1'b1;
    end
  end

  // A repeated value still completes its handshake but occupies no entry.
  always_comb begin
    w_dup   = r_seen & (io_bus.in_data == r_last);
    w_store = w_push & ~w_dup;
  end
`else
  always_comb w_store = w_push;
`endif

  // Storage is deliberately left unreset; out_data masks it while empty.
  always_ff @(posedge clk) begin
    if (w_store && !io_bus.flush) begin
      r_mem[r_wr_ptr] <= io_bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (io_bus.flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (io_bus.in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign io_bus.in_ready  = ~w_full;
  assign io_bus.out_valid = ~w_empty;
  assign io_bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign io_bus.count     = r_count;
  assign io_bus.full      = w_full;
  assign io_bus.empty     = w_empty;
  assign io_bus.overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_capture_fifo.sv
// Directed bench for nibble_capture_fifo: fill/overflow, drain, wrap, flush, async reset, change capture.
module tb_nibble_capture_fifo;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  nibble_capture_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  nibble_capture_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [3:0] exp);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 1);
    check_eq({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] q[$];
  logic [3:0] got[$];
  logic [3:0] beats[6];
  logic [3:0] d;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // reset state
    #12;
    check_eq("rst_count",    32'(bus.count), 0);
    check_eq("rst_empty",    32'(bus.empty), 1);
    check_eq("rst_full",     32'(bus.full), 0);
    check_eq("rst_outvalid", 32'(bus.out_valid), 0);
    check_eq("rst_inready",  32'(bus.in_ready), 1);
    check_eq("rst_overflow", 32'(bus.overflow), 0);
    check_eq("rst_outdata",  32'(bus.out_data), 0);
    rst_n = 1'b1;
    tick();

    // 1: fill to full
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    check_eq("fill_count",   32'(bus.count), 4);
    check_eq("fill_full",    32'(bus.full), 1);
    check_eq("fill_inready", 32'(bus.in_ready), 0);
    check_eq("fill_outdata", 32'(bus.out_data), 1);

    // 2: offer while full, then drain
    push(4'h5);
    check_eq("ovf_flag",  32'(bus.overflow), 1);
    check_eq("ovf_count", 32'(bus.count), 4);
    check_eq("ovf_head",  32'(bus.out_data), 1);
    pop_check("drain0", 4'h1);
    pop_check("drain1", 4'h2);
    pop_check("drain2", 4'h3);
    pop_check("drain3", 4'h4);
    check_eq("drain_empty",   32'(bus.empty), 1);
    check_eq("drain_outdata", 32'(bus.out_data), 0);
    check_eq("drain_sticky",  32'(bus.overflow), 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_eq("flush_ovf_clr", 32'(bus.overflow), 0);

    // 3: simultaneous push/pop at count 2 with pointer wrap
    push(4'h4); push(4'h5);
    q = '{4'h4, 4'h5};
    for (int i = 0; i < 6; i++) begin
      d = 4'(6 + i);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b1;
      check_eq("mix_data", 32'(bus.out_data), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(d);
      tick();
      check_eq("mix_count", 32'(bus.count), 2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    pop_check("mix_tail0", 4'hA);
    pop_check("mix_tail1", 4'hB);
    check_eq("mix_empty", 32'(bus.empty), 1);

    // 4: flush beats a simultaneous push
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    push(4'h5);
    pop_check("pre_flush", 4'h1);
    check_eq("pre_flush_count", 32'(bus.count), 3);
    check_eq("pre_flush_ovf",   32'(bus.overflow), 1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_count", 32'(bus.count), 0);
    check_eq("flush_empty", 32'(bus.empty), 1);
    check_eq("flush_ovf",   32'(bus.overflow), 0);
    push(4'h8);
    check_eq("post_flush_count", 32'(bus.count), 1);
    pop_check("post_flush", 4'h8);

    // 5: asynchronous reset between edges
    push(4'h1); push(4'h2); push(4'h3);
    check_eq("pre_rst_count", 32'(bus.count), 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_count",    32'(bus.count), 0);
    check_eq("arst_empty",    32'(bus.empty), 1);
    check_eq("arst_outvalid", 32'(bus.out_valid), 0);
    check_eq("arst_outdata",  32'(bus.out_data), 0);
    #2;
    rst_n = 1'b1;
    push(4'h9);
    check_eq("post_rst_count", 32'(bus.count), 1);
    pop_check("post_rst", 4'h9);

    // 6: repeated values
    beats = '{4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h7};
`ifdef CAPTURE_CHANGES_EN
    for (int i = 0; i < 6; i++) begin
      check_eq("dedup_inready", 32'(bus.in_ready), 1);
      push(beats[i]);
    end
    check_eq("dedup_count", 32'(bus.count), 3);
    pop_check("dedup0", 4'h7);
    pop_check("dedup1", 4'h0);
    pop_check("dedup2", 4'h7);
    check_eq("dedup_empty", 32'(bus.empty), 1);
`else
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("all_inready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      if (bus.out_valid) got.push_back(bus.out_data);
      tick();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && bus.out_valid; k++) begin
      got.push_back(bus.out_data);
      tick();
    end
    bus.out_ready = 1'b0;
    check_eq("all_len", 32'(got.size()), 6);
    for (int i = 0; i < 6; i++) begin
      check_eq("all_data", 32'((i < got.size()) ? got[i] : 4'hF), 32'(beats[i]));
    end
    check_eq("all_empty", 32'(bus.empty), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
